// File: rtl/bus_mux_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin bus mux arbiter.
// Holds the state encoding, the requester count and the round-robin search helper.
package bus_mux_arbiter4_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int N_REQ     = 4;
  localparam int W_DEFAULT = 2;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First set bit of req, searching upward from start with wrap-around.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] start);
    pick_t      p;
    logic [1:0] k;
    p = '0;
    // Scan from the farthest offset down so the nearest candidate is written last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = start + 2'(i);
      if (req[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bus_mux_arbiter4_mux.sv
// Combinational W-bit 4:1 multiplexer driven by the arbiter's registered select.
module bus_mux4
  import bus_mux_arbiter4_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = i0;
    case (sel)
      2'd1:    y = i1;
      2'd2:    y = i2;
      2'd3:    y = i3;
      default: y = i0;
    endcase
  end

endmodule

// File: rtl/bus_mux_arbiter4.sv
// Round-robin arbiter sharing a 4:1 data mux among four requesters, with a
// bounded tenure while contested and a registered data output.
module bus_mux_arbiter4
  import bus_mux_arbiter4_pkg::*;
#(
  parameter int W        = W_DEFAULT,
  parameter int HOLD_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [W-1:0] o,
  output logic         o_valid
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_e       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   sel_q, sel_d;
  logic [3:0]   hold_q, hold_d;
  logic [3:0]   gnt_q, gnt_d;
  logic [W-1:0] o_q, o_d;
  logic         o_valid_q, o_valid_d;

  logic [W-1:0] mux_y;
  logic [3:0]   others;
  pick_t        pick_all, pick_oth;
  logic         grant_en;
  logic [1:0]   grant_idx;

  bus_mux4 #(.W(W)) u_mux (
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .i3  (i3),
    .sel (sel_q),
    .y   (mux_y)
  );

  assign others   = req & ~(4'b0001 << sel_q);
  assign pick_all = rr_pick(req, ptr_q);
  assign pick_oth = rr_pick(others, ptr_q);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    grant_en  = 1'b0;
    grant_idx = pick_all.idx;

    if (state_q == IDLE) begin
      if (pick_all.found) grant_en = 1'b1;
      else                gnt_d    = '0;
    end else if (!req[sel_q]) begin
      // Owner released: hand over on this same edge if anyone else is waiting.
      if (pick_all.found) begin
        grant_en = 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end else if (pick_oth.found) begin
      if (hold_q >= HOLD_LIM) begin
        grant_en  = 1'b1;
        grant_idx = pick_oth.idx;
      end else begin
        hold_d = hold_q + 4'd1;
      end
    end else if (hold_q < HOLD_LIM) begin
      hold_d = hold_q + 4'd1;
    end

    if (grant_en) begin
      state_d = BUSY;
      gnt_d   = 4'b0001 << grant_idx;
      sel_d   = grant_idx;
      ptr_d   = grant_idx + 2'd1;
      hold_d  = 4'd1;
    end

    o_valid_d = |gnt_q;
    o_d       = (|gnt_q) ? mux_y : o_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, outputs included.
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign o       = o_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_bus_mux_arbiter4.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural owner/tenure model.
module tb_bus_mux_arbiter4;

  localparam int W        = 2;
  localparam int HOLD_MAX = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [W-1:0] din [4];
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] o;
  logic         o_valid;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: who owns the bus, for how long, and where the search starts.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_ten   = 0;
  int m_sel   = 0;
  int m_o     = 0;
  int m_ov    = 0;

  bus_mux_arbiter4 #(.W(W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .i0      (din[0]),
    .i1      (din[1]),
    .i2      (din[2]),
    .i3      (din[3]),
    .gnt     (gnt),
    .sel     (sel),
    .o       (o),
    .o_valid (o_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  excl;
    bit  want_new;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_ten = 0; m_sel = 0; m_o = 0; m_ov = 0;
      return;
    end
    // Output stage sees the selection made on the previous edge.
    m_ov = (m_owner >= 0) ? 1 : 0;
    if (m_ov == 1) m_o = int'(din[m_sel]);

    want_new = 1'b0;
    excl     = -1;
    if (m_owner < 0) begin
      want_new = (req != 4'b0);
    end else if (!req[m_owner]) begin
      if (req != 4'b0) want_new = 1'b1;
      else             m_owner  = -1;
    end else begin
      int others_cnt;
      others_cnt = $countones(req) - 1;
      if (others_cnt > 0 && m_ten >= HOLD_MAX) begin
        want_new = 1'b1;
        excl     = m_owner;
      end else begin
        m_ten = (m_ten + 1 > HOLD_MAX) ? HOLD_MAX : m_ten + 1;
      end
    end

    if (want_new) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (m_ptr + i) % 4;
        if (req[k] && k != excl) begin
          m_owner = k;
          m_sel   = k;
          m_ptr   = (k + 1) % 4;
          m_ten   = 1;
          break;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("gnt",     gnt,     (m_owner < 0) ? 0 : (1 << m_owner));
    check("sel",     sel,     m_sel);
    check("o_valid", o_valid, m_ov);
    check("o",       o,       m_o);
    check("gnt_onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = W'(i);

    // Reset with all requesting, then full contention rotation.
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    step();
    check("rst_gnt", gnt, 0);
    check("rst_sel", sel, 0);
    check("rst_o", o, 0);
    check("rst_o_valid", o_valid, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 17; c++) begin
      step();
      check("contention_gnt", gnt, 1 << ((c / 4) % 4));
    end

    // Single requester.
    do_reset();
    req    = 4'b0100;
    din[2] = 2'b10;
    step();
    check("single_gnt", gnt, 4'b0100);
    check("single_sel", sel, 2);
    step();
    check("single_o", o, 2'b10);
    check("single_o_valid", o_valid, 1);

    // Early release hands over with no idle gap.
    do_reset();
    req = 4'b0011;
    step();
    check("early_first_gnt", gnt, 4'b0001);
    req = 4'b0010;
    step();
    check("early_handover_gnt", gnt, 4'b0010);
    check("early_ptr", dut.ptr_q, 2);

    // Uncontested hold saturates, then contention rotates at once.
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      check("uncontested_gnt", gnt, 4'b0001);
    end
    check("uncontested_hold", dut.hold_q, 4);
    req = 4'b0011;
    step();
    check("contest_rotate_gnt", gnt, 4'b0010);

    // Reset mid-tenure drops everything; arbitration restarts from 0.
    do_reset();
    req = 4'b1000;
    step();
    check("mid_owner_gnt", gnt, 4'b1000);
    rst_n = 1'b0;
    step();
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_o_valid", o_valid, 0);
    check("mid_rst_o", o, 0);
    rst_n = 1'b1;
    req   = 4'b1001;
    step();
    check("mid_restart_gnt", gnt, 4'b0001);

    // Randomized traffic with sticky requests and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) din[i] = W'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
